// File: rtl/opcodes.sv
// Shared datapath control encodings for the 8-bit accumulator CPU.
package opcodes;
  typedef enum logic [2:0] {FnPassA, FnAdd, FnSub, FnAnd, FnOr, FnXor} alu_functions_t;
  typedef enum logic {PcInc, PcJmp} PcSel_t;
endpackage

// File: rtl/control_fsm.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU: latches the instruction word,
// decodes it into datapath strobes, and handles single-step, the switch handshake and halt.
//
// state      | meaning
// st_fetch   | latch MemData into ir; leave on Run or a pending step
// st_exec    | single decode cycle of ir, strobes driven
// st_wait_sw | IN waiting on synced SwValid; exit cycle writes the switch value
// st_halt    | absorbing stop, left only through nReset
module control_fsm #(
  parameter int n    = 8,
  parameter int SYNC = 2
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic [n-1:0]            MemData,
  input  logic                    AccZero,
  input  logic                    Run,
  input  logic                    Step,
  input  logic                    SwValid,
  output logic                    RegWe,
  output logic                    ImmSel,
  output logic                    WDataSel,
  output logic                    AccStore,
  output logic                    Op1Sel,
  output logic                    PcWe,
  output opcodes::alu_functions_t AluOp,
  output opcodes::PcSel_t         PcSel,
  output logic                    SwAck,
  output logic                    Halted,
  output logic                    Illegal
);
  import opcodes::*;

  typedef enum logic [1:0] {st_fetch, st_exec, st_wait_sw, st_halt} state_t;

  state_t          state, state_nxt;
  logic [n-1:0]    ir;
  logic [3:0]      opcode;
  logic [SYNC-1:0] step_sync, sw_sync;
  logic            step_d, step_rise, sw_ready;
  logic            step_pend, step_clr, halt_set, illegal_set;
  logic            ir_unused;

  assign opcode    = ir[n-1:n-4];
  // operand bits go straight from MemData to the datapath; only the opcode matters here
  assign ir_unused = ^ir[n-5:0];
  assign step_rise = step_sync[SYNC-1] & ~step_d;
  assign sw_ready  = sw_sync[SYNC-1];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      step_sync <= '0;
      sw_sync   <= '0;
      step_d    <= 1'b0;
    end else begin
      step_sync <= {step_sync[SYNC-2:0], Step};
      sw_sync   <= {sw_sync[SYNC-2:0], SwValid};
      step_d    <= step_sync[SYNC-1];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= st_fetch;
      ir        <= '0;
      step_pend <= 1'b0;
      Halted    <= 1'b0;
      Illegal   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == st_fetch)
        ir <= MemData;
      // a new edge wins over the clear so a press landing on the release is not lost
      if (step_rise && !Run && state != st_halt)
        step_pend <= 1'b1;
      else if (step_clr)
        step_pend <= 1'b0;
      if (halt_set)
        Halted <= 1'b1;
      if (illegal_set)
        Illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    RegWe       = 1'b0;
    ImmSel      = 1'b0;
    WDataSel    = 1'b0;
    AccStore    = 1'b0;
    Op1Sel      = 1'b0;
    PcWe        = 1'b0;
    AluOp       = FnPassA;
    PcSel       = PcInc;
    SwAck       = 1'b0;
    step_clr    = 1'b0;
    halt_set    = 1'b0;
    illegal_set = 1'b0;

    case (state)
      st_fetch: begin
        if (Run || step_pend) begin
          state_nxt = st_exec;
          step_clr  = 1'b1;
        end
      end

      st_exec: begin
        PcWe      = 1'b1;
        state_nxt = st_fetch;
        case (opcode)
          4'h0: ;
          4'h1: begin Op1Sel = 1'b1; AccStore = 1'b1; end
          4'h2: begin Op1Sel = 1'b1; ImmSel = 1'b1; AluOp = FnOr; AccStore = 1'b1; end
          4'h3: AccStore = 1'b1;
          4'h4: RegWe = 1'b1;
          4'h5: begin AluOp = FnAdd; AccStore = 1'b1; end
          4'h6: begin AluOp = FnSub; AccStore = 1'b1; end
          4'h7: begin AluOp = FnAnd; AccStore = 1'b1; end
          4'h8: begin AluOp = FnOr;  AccStore = 1'b1; end
          4'h9: begin AluOp = FnXor; AccStore = 1'b1; end
          4'hA: begin Op1Sel = 1'b1; AluOp = FnAdd; AccStore = 1'b1; end
          4'hB: begin PcWe = 1'b0; state_nxt = st_wait_sw; end
          4'hC: PcSel = PcJmp;
          4'hD: PcSel = AccZero ? PcJmp : PcInc;
          4'hE: begin PcWe = 1'b0; state_nxt = st_halt; halt_set = 1'b1; end
          default: begin
            PcWe        = 1'b0;
            state_nxt   = st_halt;
            halt_set    = 1'b1;
            illegal_set = 1'b1;
          end
        endcase
      end

      st_wait_sw: begin
        if (sw_ready) begin
          RegWe     = 1'b1;
          WDataSel  = 1'b1;
          SwAck     = 1'b1;
          PcWe      = 1'b1;
          state_nxt = st_fetch;
        end
      end

      st_halt: ;

      default: state_nxt = st_fetch;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: a small datapath/ROM environment plus an instruction-level
// reference model of the CPU used to predict final state and cycle counts.
module tb_control_fsm;
  import opcodes::*;

  logic           Clock, nReset;
  logic [7:0]     MemData;
  logic           AccZero, Run, Step, SwValid;
  logic           RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe;
  alu_functions_t AluOp;
  PcSel_t         PcSel;
  logic           SwAck, Halted, Illegal;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rom [256];
  logic [7:0] regs [16];
  logic [7:0] m_regs [16];
  logic [7:0] pc, acc, sw_val, op1, alu;
  int pcwe_cnt = 0;
  int strobe_cnt = 0;

  control_fsm #(.n(8), .SYNC(2)) dut (
    .Clock(Clock), .nReset(nReset), .MemData(MemData), .AccZero(AccZero),
    .Run(Run), .Step(Step), .SwValid(SwValid),
    .RegWe(RegWe), .ImmSel(ImmSel), .WDataSel(WDataSel), .AccStore(AccStore),
    .Op1Sel(Op1Sel), .PcWe(PcWe), .AluOp(AluOp), .PcSel(PcSel),
    .SwAck(SwAck), .Halted(Halted), .Illegal(Illegal)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // datapath environment driven by the strobes
  assign MemData = rom[pc];
  assign AccZero = (acc == 8'h00);

  always_comb begin
    op1 = Op1Sel ? (ImmSel ? {MemData[3:0], 4'h0} : {4'h0, MemData[3:0]}) : regs[MemData[3:0]];
    case (AluOp)
      FnAdd:   alu = acc + op1;
      FnSub:   alu = acc - op1;
      FnAnd:   alu = acc & op1;
      FnOr:    alu = acc | op1;
      FnXor:   alu = acc ^ op1;
      default: alu = op1;
    endcase
  end

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc  <= 8'h00;
      acc <= 8'h00;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      if (AccStore) acc <= alu;
      if (RegWe) regs[MemData[3:0]] <= WDataSel ? sw_val : acc;
      if (PcWe) pc <= (PcSel == PcJmp) ? alu : pc + 8'd1;
      if (PcWe) pcwe_cnt <= pcwe_cnt + 1;
      if (|{RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe, SwAck}) strobe_cnt <= strobe_cnt + 1;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hE0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge Clock);
      if (Halted === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // instruction-level model: 2 cycles per instruction, IN costs 3 with SwValid already high
  task automatic ref_run(output int cyc, output logic [7:0] a, output logic [7:0] p,
                         output logic ill, output logic done);
    logic [7:0] ins, nxt;
    logic [3:0] x;
    a = 8'h00; p = 8'h00; cyc = 0; ill = 1'b0; done = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    for (int s = 0; s < 200 && !done; s++) begin
      ins = rom[p];
      x   = ins[3:0];
      nxt = p + 8'd1;
      cyc += 2;
      case (ins[7:4])
        4'h0: ;
        4'h1: a = {4'h0, x};
        4'h2: a = a | {x, 4'h0};
        4'h3: a = m_regs[x];
        4'h4: m_regs[x] = a;
        4'h5: a = a + m_regs[x];
        4'h6: a = a - m_regs[x];
        4'h7: a = a & m_regs[x];
        4'h8: a = a | m_regs[x];
        4'h9: a = a ^ m_regs[x];
        4'hA: a = a + {4'h0, x};
        4'hB: begin m_regs[x] = sw_val; cyc += 1; end
        4'hC: nxt = m_regs[x];
        4'hD: if (a == 8'h00) nxt = m_regs[x];
        4'hE: begin done = 1'b1; nxt = p; end
        default: begin done = 1'b1; ill = 1'b1; nxt = p; end
      endcase
      p = nxt;
    end
  endtask

  task automatic test_reset();
    Run = 1'b0; Step = 1'b0; SwValid = 1'b0; sw_val = 8'h00; nReset = 1'b1;
    clear_rom();
    #2 nReset = 1'b0;
    #1;
    n_cmp++; if ({RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe, SwAck} !== 7'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 0000000", {RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe, SwAck}); end
    n_cmp++; if (AluOp !== FnPassA) begin n_err++; $display("FAIL reset_aluop: got %0d expected %0d", AluOp, FnPassA); end
    n_cmp++; if (PcSel !== PcInc) begin n_err++; $display("FAIL reset_pcsel: got %0d expected %0d", PcSel, PcInc); end
    n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", Halted); end
    n_cmp++; if (Illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b expected 0", Illegal); end
  endtask

  task automatic test_sequence();
    int p0, s1, cyc;
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'hA2; rom[2] = 8'h45; rom[3] = 8'hE0;
    Run = 1'b1; Step = 1'b0; SwValid = 1'b0;
    do_reset();
    p0 = pcwe_cnt;
    run_to_halt(40, cyc);
    n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL seq_cycles: got %0d expected 8", cyc); end
    n_cmp++; if (regs[5] !== 8'h05) begin n_err++; $display("FAIL seq_r5: got %0h expected 05", regs[5]); end
    n_cmp++; if (pcwe_cnt - p0 !== 3) begin n_err++; $display("FAIL seq_pcwe: got %0d expected 3", pcwe_cnt - p0); end
    s1 = strobe_cnt;
    repeat (10) @(negedge Clock);
    n_cmp++; if (strobe_cnt - s1 !== 0) begin n_err++; $display("FAIL seq_after_halt: got %0d strobe cycles expected 0", strobe_cnt - s1); end
    n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL seq_sticky: got %b expected 1", Halted); end
  endtask

  task automatic test_orhi();
    int seen;
    alu_functions_t op;
    logic imm;
    clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h2A; rom[2] = 8'h4C; rom[3] = 8'hE0;
    Run = 1'b1;
    do_reset();
    seen = 0; op = FnPassA; imm = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (AccStore === 1'b1 && pc == 8'd1) begin seen++; op = AluOp; imm = ImmSel; end
      if (Halted === 1'b1) break;
    end
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL orhi_exec_count: got %0d expected 1", seen); end
    n_cmp++; if (op !== FnOr) begin n_err++; $display("FAIL orhi_aluop: got %0d expected %0d", op, FnOr); end
    n_cmp++; if (imm !== 1'b1) begin n_err++; $display("FAIL orhi_immsel: got %b expected 1", imm); end
    n_cmp++; if (acc !== 8'hAF) begin n_err++; $display("FAIL orhi_acc: got %0h expected af", acc); end
    n_cmp++; if (regs[12] !== 8'hAF) begin n_err++; $display("FAIL orhi_r12: got %0h expected af", regs[12]); end
  endtask

  task automatic test_jz();
    PcSel_t sel, exp_sel;
    logic [7:0] exp_pc;
    int cyc;
    for (int az = 0; az < 2; az++) begin
      clear_rom();
      rom[0] = 8'h17; rom[1] = 8'h43; rom[2] = (az == 1) ? 8'h10 : 8'h11;
      rom[3] = 8'hD3; rom[4] = 8'hE0; rom[7] = 8'hE0;
      exp_sel = (az == 1) ? PcJmp : PcInc;
      exp_pc  = (az == 1) ? 8'd7 : 8'd4;
      Run = 1'b1;
      do_reset();
      sel = (az == 1) ? PcInc : PcJmp;
      for (int i = 0; i < 30; i++) begin
        @(negedge Clock);
        if (PcWe === 1'b1 && pc == 8'd3) sel = PcSel;
        if (Halted === 1'b1) break;
      end
      cyc = 0;
      n_cmp++; if (sel !== exp_sel) begin n_err++; $display("FAIL jz_pcsel[acczero=%0d]: got %0d expected %0d", az, sel, exp_sel); end
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL jz_pc[acczero=%0d]: got %0d expected %0d", az, pc, exp_pc); end
    end
  endtask

  task automatic test_in_wait();
    int s0, acks, first;
    logic shape_ok;
    clear_rom();
    rom[0] = 8'hB2; rom[1] = 8'hE0;
    Run = 1'b1; SwValid = 1'b0; sw_val = 8'h5A;
    do_reset();
    s0 = strobe_cnt;
    repeat (24) @(negedge Clock);
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_err++; $display("FAIL in_idle_strobes: got %0d expected 0", strobe_cnt - s0); end
    n_cmp++; if (pc !== 8'd0) begin n_err++; $display("FAIL in_pc_frozen: got %0d expected 0", pc); end
    SwValid = 1'b1;
    acks = 0; first = 0; shape_ok = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (SwAck === 1'b1) begin
        acks++;
        if (first == 0) first = k;
        shape_ok = (RegWe === 1'b1) && (WDataSel === 1'b1) && (PcWe === 1'b1) && (PcSel === PcInc);
      end
    end
    n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL in_ack_count: got %0d expected 1", acks); end
    n_cmp++; if (first !== 2) begin n_err++; $display("FAIL in_ack_latency: got %0d expected 2", first); end
    n_cmp++; if (shape_ok !== 1'b1) begin n_err++; $display("FAIL in_ack_strobes: got %b expected 1", shape_ok); end
    n_cmp++; if (regs[2] !== 8'h5A) begin n_err++; $display("FAIL in_r2: got %0h expected 5a", regs[2]); end
    n_cmp++; if (Halted !== 1'b1 || pc !== 8'd1) begin n_err++; $display("FAIL in_after: got halted=%b pc=%0d expected halted=1 pc=1", Halted, pc); end
    SwValid = 1'b0;
  endtask

  task automatic test_step();
    int p0;
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;
    Run = 1'b0; Step = 1'b0; SwValid = 1'b0;
    do_reset();
    p0 = pcwe_cnt;
    repeat (8) @(negedge Clock);
    n_cmp++; if (pc !== 8'd0) begin n_err++; $display("FAIL step_idle_pc: got %0d expected 0", pc); end
    for (int s = 0; s < 3; s++) begin
      Step = 1'b1; repeat (3) @(negedge Clock);
      Step = 1'b0; repeat (3) @(negedge Clock);
    end
    repeat (6) @(negedge Clock);
    n_cmp++; if (pcwe_cnt - p0 !== 3) begin n_err++; $display("FAIL step_exec_count: got %0d expected 3", pcwe_cnt - p0); end
    n_cmp++; if (pc !== 8'd3) begin n_err++; $display("FAIL step_pc: got %0d expected 3", pc); end
    Run = 1'b1; Step = 1'b1;
    repeat (4) @(negedge Clock);
    Run = 1'b0;
    repeat (6) @(negedge Clock);
    Step = 1'b0;
    repeat (10) @(negedge Clock);
    n_cmp++; if (pc !== 8'd5) begin n_err++; $display("FAIL step_during_run: got pc %0d expected 5", pc); end
    Step = 1'b1; repeat (3) @(negedge Clock);
    Step = 1'b0; repeat (6) @(negedge Clock);
    n_cmp++; if (pc !== 8'd6) begin n_err++; $display("FAIL step_resume: got pc %0d expected 6", pc); end
  endtask

  task automatic test_illegal_reset();
    int cyc;
    clear_rom();
    rom[0] = 8'hF0;
    Run = 1'b1; Step = 1'b0; SwValid = 1'b0; sw_val = 8'hC3;
    do_reset();
    run_to_halt(20, cyc);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL ill_cycles: got %0d expected 2", cyc); end
    n_cmp++; if (Illegal !== 1'b1 || Halted !== 1'b1) begin n_err++; $display("FAIL ill_flags: got halted=%b illegal=%b expected 1 1", Halted, Illegal); end
    rom[0] = 8'hB2; rom[1] = 8'hE0;
    @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    n_cmp++; if (Illegal !== 1'b0 || Halted !== 1'b0) begin n_err++; $display("FAIL ill_reset_clear: got halted=%b illegal=%b expected 0 0", Halted, Illegal); end
    @(negedge Clock);
    nReset = 1'b1;
    repeat (6) @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    n_cmp++; if ({RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe, SwAck, Halted, Illegal} !== 9'b0
                 || AluOp !== FnPassA || PcSel !== PcInc) begin
      n_err++; $display("FAIL wait_reset_outputs: got %b aluop=%0d pcsel=%0d expected all zero",
        {RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe, SwAck, Halted, Illegal}, AluOp, PcSel); end
    SwValid = 1'b1;
    repeat (3) @(negedge Clock);
    n_cmp++; if (SwAck !== 1'b0 || pc !== 8'd0) begin n_err++; $display("FAIL wait_reset_hold: got swack=%b pc=%0d expected 0 0", SwAck, pc); end
    nReset = 1'b1;
    run_to_halt(30, cyc);
    n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL wait_reset_rerun: got %0d cycles expected 5", cyc); end
    n_cmp++; if (regs[2] !== 8'hC3) begin n_err++; $display("FAIL wait_reset_r2: got %0h expected c3", regs[2]); end
    SwValid = 1'b0;
  endtask

  task automatic test_random();
    int exp_cyc, cyc, tries;
    logic [7:0] exp_acc, exp_pc;
    logic exp_ill, ok;
    for (int t = 0; t < 30; t++) begin
      ok = 1'b0; tries = 0;
      while (!ok && tries < 50) begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        sw_val = 8'($urandom);
        ref_run(exp_cyc, exp_acc, exp_pc, exp_ill, ok);
        tries++;
      end
      if (!ok) begin
        clear_rom();
        ref_run(exp_cyc, exp_acc, exp_pc, exp_ill, ok);
      end
      Run = 1'b1; Step = 1'b0; SwValid = 1'b1;
      do_reset();
      run_to_halt(exp_cyc + 20, cyc);
      n_cmp++; if (cyc !== exp_cyc) begin n_err++; $display("FAIL rand[%0d]_cycles: got %0d expected %0d", t, cyc, exp_cyc); end
      n_cmp++; if (acc !== exp_acc) begin n_err++; $display("FAIL rand[%0d]_acc: got %0h expected %0h", t, acc, exp_acc); end
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL rand[%0d]_pc: got %0h expected %0h", t, pc, exp_pc); end
      n_cmp++; if (Illegal !== exp_ill) begin n_err++; $display("FAIL rand[%0d]_illegal: got %b expected %b", t, Illegal, exp_ill); end
      for (int r = 0; r < 16; r++) begin
        n_cmp++; if (regs[r] !== m_regs[r]) begin n_err++; $display("FAIL rand[%0d]_r%0d: got %0h expected %0h", t, r, regs[r], m_regs[r]); end
      end
    end
    SwValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_orhi();
    test_jz();
    test_in_wait();
    test_step();
    test_illegal_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
